// File: rtl/lsu_mem_initiator.sv
// Load/store initiator for the asynchronous RAM data port: one request at a time, strobes held for programmable cycles.
// Optional build macro MISALIGN_CHECK_EN rejects misaligned half/word accesses.
module lsu_mem_initiator #(
    parameter logic [31:0] START_ADDR   = 32'h0000_0000,
    parameter int          MEM_SIZE     = 65536,
    parameter int          READ_LATENCY = 1,
    parameter int          WRITE_HOLD   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_write_enable,
    output logic        mem_read_enable,
    output logic [1:0]  mem_bw,
    output logic [31:0] mem_write_address,
    output logic [31:0] mem_read_address,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out
);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_RESP} state_t;

    localparam logic [31:0] LAST_OFF = 32'(MEM_SIZE - 4);

    state_t      r_state, w_state_nx;
    logic        r_req_ready, r_resp_valid, r_resp_err, r_we_en, r_re_en, r_signed;
    logic [1:0]  r_size, r_bw;
    logic [3:0]  r_cnt;
    logic [31:0] r_resp_rdata, r_waddr, r_raddr, r_wdata;
    logic        w_accept, w_misalign, w_reject, w_wr_last, w_rd_last;
    logic        w_req_ready_d, w_resp_valid_d;
    logic [31:0] w_off, w_ext;
    logic [1:0]  w_bw;

    assign w_accept = r_req_ready & req_valid;
    assign w_off    = req_addr - START_ADDR;
`ifdef MISALIGN_CHECK_EN
    assign w_misalign = (req_size == 2'b01 && req_addr[0]) || (req_size[1] && req_addr[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif
    assign w_reject  = (w_off > LAST_OFF) || w_misalign;
    // Write enable is low in the first WRITE cycle (address setup), so a high enable marks the hold phase.
    assign w_wr_last = (r_state == S_WRITE) && r_we_en && (r_cnt == 4'd0);
    assign w_rd_last = (r_state == S_READ) && (r_cnt == 4'd0);

    always_comb begin
        case (req_size)
            2'b00:   w_bw = 2'b00;
            2'b01:   w_bw = 2'b10;
            default: w_bw = 2'b11;
        endcase
    end

    always_comb begin
        case (r_size)
            2'b00:   w_ext = {{24{r_signed & mem_data_out[7]}}, mem_data_out[7:0]};
            2'b01:   w_ext = {{16{r_signed & mem_data_out[15]}}, mem_data_out[15:0]};
            default: w_ext = mem_data_out;
        endcase
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nx;
    end

    // FSM: next state
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nx = w_reject ? S_RESP : (req_we ? S_WRITE : S_READ);
            S_WRITE: if (w_wr_last) w_state_nx = S_RESP;
            S_READ:  if (w_rd_last) w_state_nx = S_RESP;
            S_RESP:  if (resp_ready) w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    // FSM: handshake outputs are decoded from the next state and then registered
    always_comb begin
        w_req_ready_d  = (w_state_nx == S_IDLE);
        w_resp_valid_d = (w_state_nx == S_RESP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_ready  <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
            r_we_en      <= 1'b0;
            r_re_en      <= 1'b0;
            r_bw         <= '0;
            r_waddr      <= '0;
            r_raddr      <= '0;
            r_wdata      <= '0;
            r_size       <= '0;
            r_signed     <= 1'b0;
            r_cnt        <= '0;
        end else begin
            r_req_ready  <= w_req_ready_d;
            r_resp_valid <= w_resp_valid_d;
            if (w_accept) begin
                r_size       <= req_size;
                r_signed     <= req_signed;
                r_bw         <= w_bw;
                r_waddr      <= req_addr;
                r_raddr      <= req_addr;
                r_wdata      <= req_wdata;
                r_resp_rdata <= '0;
                r_resp_err   <= w_reject;
                if (!w_reject && !req_we) begin
                    r_re_en <= 1'b1;
                    r_cnt   <= 4'(READ_LATENCY - 1);
                end
            end
            case (r_state)
                S_WRITE: begin
                    if (!r_we_en) begin
                        r_we_en <= 1'b1;
                        r_cnt   <= 4'(WRITE_HOLD - 1);
                    end else if (r_cnt == 4'd0) begin
                        r_we_en <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_READ: begin
                    if (r_cnt == 4'd0) begin
                        r_re_en      <= 1'b0;
                        r_resp_rdata <= w_ext;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready         = r_req_ready;
    assign resp_valid        = r_resp_valid;
    assign resp_rdata        = r_resp_rdata;
    assign resp_err          = r_resp_err;
    assign mem_write_enable  = r_we_en;
    assign mem_read_enable   = r_re_en;
    assign mem_bw            = r_bw;
    assign mem_write_address = r_waddr;
    assign mem_read_address  = r_raddr;
    assign mem_data_in       = r_wdata;

endmodule
